// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the round-robin ALU sequencer: op codes, flag codes,
// FSM state encoding and the illegal-op helper.
package alu_ctrl_pkg;

    localparam int ALU_DW = 6;
    localparam int ALU_SW = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    localparam logic [1:0] FLAG_N  = 2'b00;
    localparam logic [1:0] FLAG_OC = 2'b01;
    localparam logic [1:0] FLAG_B  = 2'b10;
    localparam logic [1:0] FLAG_Z  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Codes 110 and 111 have no defined ALU operation.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request, response and ALU-side signals of the sequencer. The slave modport is
// the sequencer's view; the master modport is the requester/consumer/ALU side.
interface alu_rr_sequencer_if #(
    parameter int DW = 6,
    parameter int SW = 3
);
    logic          req0_valid;
    logic          req0_ready;
    logic [SW-1:0] req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;

    logic          req1_valid;
    logic          req1_ready;
    logic [SW-1:0] req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic [1:0]    rsp_flag;
    logic          rsp_err;

    logic [SW-1:0] alu_s;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic [1:0]    alu_f;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_result, alu_f,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_err,
        output alu_s, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_result, alu_f,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_err,
        input  alu_s, alu_a, alu_b
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the requester that was not served last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);
    assign gnt0 = valid0 & (~valid1 | last_gnt);
    assign gnt1 = valid1 & (~valid0 | ~last_gnt);
endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one registered ALU between two requesters with round-robin arbitration.
// Optional macro OP_CHECK_EN: reject op codes 110/111 with rsp_err instead of issuing them.
//
// state | meaning
// IDLE  | waiting for a request; granted requester sees ready
// ISSUE | latched op on ALU inputs, ALU samples at closing edge
// WAIT  | ALU output valid, captured at closing edge
// HOLD  | response presented until rsp_ready
module alu_rr_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int SW = ALU_SW
) (
    input  logic              clk,
    input  logic              rst,
    alu_rr_sequencer_if.slave bus,
    output logic              busy
);
    state_t        state, state_nxt;
    logic          gnt0, gnt1;
    logic          accept;
    logic          go_hold;
    logic          last_gnt;
    logic          id_q;
    logic [SW-1:0] sel_op, op_q;
    logic [DW-1:0] sel_a, sel_b, a_q, b_q;
    logic [DW-1:0] result_q;
    logic [1:0]    flag_q;

    rr_arb2 u_arb (
        .valid0   (bus.req0_valid),
        .valid1   (bus.req1_valid),
        .last_gnt (last_gnt),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign accept = (state == ST_IDLE) & (gnt0 | gnt1);
    assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;
    assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;

`ifdef OP_CHECK_EN
    logic err_q;

    assign go_hold = op_is_illegal(sel_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= go_hold;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign go_hold     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req0_ready = gnt0;
                bus.req1_ready = gnt1;
                if (accept) begin
                    state_nxt = go_hold ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Result is cleared on accept so a rejected op reports zero; a legal op
    // overwrites it from the ALU in WAIT, the only cycle the ALU output is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            last_gnt <= 1'b1;
            result_q <= '0;
            flag_q   <= FLAG_N;
        end else begin
            if (accept) begin
                op_q     <= sel_op;
                a_q      <= sel_a;
                b_q      <= sel_b;
                id_q     <= gnt1;
                last_gnt <= gnt1;
                result_q <= '0;
                flag_q   <= FLAG_N;
            end
            if (state == ST_WAIT) begin
                result_q <= bus.alu_result;
                flag_q   <= bus.alu_f;
            end
        end
    end

    assign bus.alu_s      = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = (state == ST_HOLD);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flag   = flag_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer with a behavioural registered ALU,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_alu_rr_sequencer;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    alu_rr_sequencer_if #(.DW(6), .SW(3)) bus ();

    alu_rr_sequencer #(.DW(6), .SW(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mlast;

    // Plain-arithmetic ALU: returns {flag, result}
    function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [5:0] a, input logic [5:0] b);
        int ai, bi, r, res;
        logic [1:0] f;
        ai = int'(a);
        bi = int'(b);
        case (s)
            3'd0:    r = ai + bi;
            3'd1:    r = ai - bi;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = 63 - ai;
            default: r = int'(a ^ b);
        endcase
        res = (r + 64) % 64;
        if (s == 3'd0 && r > 63)      f = 2'b01;
        else if (s == 3'd1 && r < 0)  f = 2'b10;
        else if (res == 0)            f = 2'b11;
        else                          f = 2'b00;
        return {f, res[5:0]};
    endfunction

    // Stand-in for the external registered ALU (no reset)
    always @(posedge clk) begin
        logic [7:0] v;
        v = alu_ref(bus.alu_s, bus.alu_a, bus.alu_b);
        bus.alu_result <= v[5:0];
        bus.alu_f      <= v[7:6];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_op(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                             output logic [5:0] res, output logic [1:0] flag,
                             output logic err, output int lat);
        logic [7:0] v;
        v    = alu_ref(op, a, b);
        res  = v[5:0];
        flag = v[7:6];
        err  = 1'b0;
        lat  = 3;
`ifdef OP_CHECK_EN
        if (op >= 3'd6) begin
            res  = 6'd0;
            flag = 2'b00;
            err  = 1'b1;
            lat  = 1;
        end
`endif
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        mlast = 1;
    endtask

    // Called at posedge+1 while IDLE with requests already driven; w is the expected winner.
    task automatic run_op(input int w, input logic [5:0] exp_res, input logic [1:0] exp_flag,
                          input logic exp_err, input int exp_lat, input int stall);
        int cnt;
        logic rdy_w, rdy_l;
        #1;
        cnt = 0;
        rdy_w = (w == 0) ? bus.req0_ready : bus.req1_ready;
        while (rdy_w !== 1'b1 && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
            rdy_w = (w == 0) ? bus.req0_ready : bus.req1_ready;
        end
        check("grant_wait", 32'(cnt), 32'd0);
        rdy_l = (w == 0) ? bus.req1_ready : bus.req0_ready;
        check("loser_ready", 32'(rdy_l), 32'd0);
        bus.rsp_ready = (stall == 0);
        @(posedge clk); #1;
        if (w == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        mlast = w;
        cnt = 1;
        while (bus.rsp_valid !== 1'b1 && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(exp_lat));
        check("rsp_id", 32'(bus.rsp_id), 32'(w));
        check("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
        check("rsp_flag", 32'(bus.rsp_flag), 32'(exp_flag));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_stable",
                  32'({bus.rsp_valid, busy, bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_err, bus.rsp_flag, bus.rsp_result}),
                  32'({1'b1, 1'b1, 1'b0, 1'b0, 1'(w), exp_err, exp_flag, exp_res}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release", 32'({bus.rsp_valid, busy}), 32'd0);
    endtask

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] res;
        logic [1:0] flag;
        logic       err;
        int         lat;
        int         stall;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic       pend[2];
        logic [2:0] rop[2];
        logic [5:0] ra[2], rb[2];
        logic [5:0] eres;
        logic [1:0] eflag;
        logic       eerr;
        int         elat, w;

        vecs[0] = '{0, OP_ADD, 6'h05, 6'h03, 6'h08, FLAG_N,  1'b0, 3, 0};
        vecs[1] = '{1, OP_SUB, 6'h03, 6'h05, 6'h3E, FLAG_B,  1'b0, 3, 0};
        vecs[2] = '{0, OP_AND, 6'h2A, 6'h15, 6'h00, FLAG_Z,  1'b0, 3, 2};
        vecs[3] = '{1, OP_OR,  6'h10, 6'h01, 6'h11, FLAG_N,  1'b0, 3, 0};
        vecs[4] = '{0, OP_NOT, 6'h0F, 6'h2B, 6'h30, FLAG_N,  1'b0, 3, 1};
        vecs[5] = '{1, OP_XOR, 6'h3C, 6'h3C, 6'h00, FLAG_Z,  1'b0, 3, 0};
        vecs[6] = '{0, OP_SUB, 6'h07, 6'h07, 6'h00, FLAG_Z,  1'b0, 3, 0};
        vecs[7] = '{1, OP_ADD, 6'h20, 6'h20, 6'h00, FLAG_OC, 1'b0, 3, 0};
`ifdef OP_CHECK_EN
        vecs[8] = '{0, 3'b110, 6'h0F, 6'h3C, 6'h00, FLAG_N, 1'b1, 1, 0};
        vecs[9] = '{1, 3'b111, 6'h3F, 6'h3F, 6'h00, FLAG_N, 1'b1, 1, 2};
`else
        vecs[8] = '{0, 3'b110, 6'h0F, 6'h3C, 6'h33, FLAG_N, 1'b0, 3, 0};
        vecs[9] = '{1, 3'b111, 6'h3F, 6'h3F, 6'h00, FLAG_Z, 1'b0, 3, 2};
`endif

        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        do_reset();

        // Reset state
        #1;
        check("reset_state",
              32'({busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_flag, bus.rsp_result, bus.alu_s, bus.alu_a, bus.alu_b,
                   bus.req0_ready, bus.req1_ready}), 32'd0);
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            run_op(vecs[i].id, vecs[i].res, vecs[i].flag, vecs[i].err, vecs[i].lat, vecs[i].stall);
        end

        // Contention from reset: grant order 0,1,0,1
        do_reset();
        set_req(0, OP_ADD, 6'h3F, 6'h01);
        set_req(1, OP_ADD, 6'h01, 6'h02);
        run_op(0, 6'h00, FLAG_OC, 1'b0, 3, 0);
        set_req(0, OP_AND, 6'h3F, 6'h15);
        run_op(1, 6'h03, FLAG_N, 1'b0, 3, 0);
        set_req(1, OP_SUB, 6'h10, 6'h01);
        run_op(0, 6'h15, FLAG_N, 1'b0, 3, 0);
        run_op(1, 6'h0F, FLAG_N, 1'b0, 3, 0);

        // Long HOLD stall with the other requester waiting, then immediate re-accept
        set_req(0, OP_OR, 6'h21, 6'h12);
        set_req(1, OP_ADD, 6'h02, 6'h02);
        run_op(0, 6'h33, FLAG_N, 1'b0, 3, 5);
        run_op(1, 6'h04, FLAG_N, 1'b0, 3, 0);

        // Reset during WAIT discards the op and restores priority to requester 0
        set_req(0, OP_ADD, 6'h01, 6'h01);
        run_op(0, 6'h02, FLAG_N, 1'b0, 3, 0);
        set_req(0, OP_ADD, 6'h01, 6'h01);
        set_req(1, OP_XOR, 6'h3F, 6'h00);
        #1;
        check("rr_after_req0", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("in_wait", 32'({busy, bus.rsp_valid, bus.alu_a}), 32'({1'b1, 1'b0, 6'h3F}));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_wait",
              32'({busy, bus.rsp_valid, bus.rsp_result, bus.rsp_flag, bus.rsp_id, bus.alu_s, bus.alu_a, bus.alu_b}), 32'd0);
        rst = 1'b0;
        mlast = 1;
        #1;
        check("first_grant_after_rst", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_ghost_rsp", 32'({bus.rsp_valid, busy}), 32'd0);
        end

        // Randomized traffic against the reference model
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    rop[i]  = 3'($urandom_range(0, 7));
                    ra[i]   = 6'($urandom_range(0, 63));
                    rb[i]   = 6'($urandom_range(0, 63));
                    set_req(i, rop[i], ra[i], rb[i]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w       = int'($urandom_range(0, 1));
                pend[w] = 1'b1;
                rop[w]  = 3'($urandom_range(0, 7));
                ra[w]   = 6'($urandom_range(0, 63));
                rb[w]   = 6'($urandom_range(0, 63));
                set_req(w, rop[w], ra[w], rb[w]);
            end
            if (pend[0] && pend[1]) w = (mlast == 0) ? 1 : 0;
            else                    w = pend[0] ? 0 : 1;
            expect_op(rop[w], ra[w], rb[w], eres, eflag, eerr, elat);
            run_op(w, eres, eflag, eerr, elat, int'($urandom_range(0, 3)));
            pend[w] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
Two-requester controller that shares one registered 6-bit ALU (s/a/b in, f/result out, one clk of latency, no reset) between two clients. It arbitrates round-robin, latches the granted operation, drives the ALU, captures result and flag, and returns them on a valid/ready response channel tagged with the requester id. It sits between the ALU and its users; the ALU is instantiated beside it at the next level up.

Parameters:
DW, 6, operand/result width (must match the ALU)
SW, 3, op-select width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 accepted this cycle
req0_op  in  SW  op code (000 add, 001 sub, 010 and, 011 or, 100 not, 101 xor)
req0_a  in  DW  operand a
req0_b  in  DW  operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
rsp_valid  out  1  response held
rsp_ready  in  1  consumer takes response
rsp_id  out  1  id of the requester that issued it
rsp_result  out  DW  ALU result
rsp_flag  out  2  ALU flag (00 normal, 01 carry, 10 borrow, 11 zero)
rsp_err  out  1  illegal op (OP_CHECK_EN only, else 0)
alu_s  out  SW  to ALU s
alu_a  out  DW  to ALU a
alu_b  out  DW  to ALU b
alu_result  in  DW  from ALU result
alu_f  in  2  from ALU f
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, dominates everything): state IDLE; rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_err 0; op/a/b latches 0, so alu_s/a/b are 0; last_gnt = 1, so requester 0 wins first; busy 0.
- Reset during ISSUE, WAIT or HOLD discards the in-flight op and produces no response. The ALU's own unreset state is never captured outside WAIT.
- FSM IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
- IDLE: grant goes to the only valid requester, or to !last_gnt if both are valid. reqN_ready is combinational, high only in IDLE for the granted requester.
- On accept (valid & ready): latch op/a/b/id, set last_gnt = id, go to ISSUE. With no valid requester, stay in IDLE.
- Requesters hold valid and payload stable until accepted. Nothing is accepted outside IDLE.
- alu_s/a/b are driven directly from the latches and stay stable through ISSUE and WAIT.
- ISSUE: the ALU samples at the closing edge. Then WAIT.
- WAIT: alu_result/alu_f are valid. Capture them into rsp_result/rsp_flag at the closing edge. Then HOLD.
- HOLD: rsp_valid = 1; rsp_* are held stable. On rsp_ready go to IDLE at the edge; rsp_valid drops the next cycle.
- Latency: accept edge to rsp_valid = 3 cycles. Peak throughput is 1 op per 4 cycles.
- The controller does not reinterpret flags; they pass through unmodified.

Optional Feature:
OP_CHECK_EN
- Defined: accepting an op >= 3'b110 goes IDLE -> HOLD directly, with rsp_result 0, rsp_flag 00, rsp_err 1; the ALU is not issued.
- Undefined: every op is forwarded unchanged (the ALU treats 110/111 as xor); rsp_err is tied 0.

Decomposition:
- Package alu_ctrl_pkg: op-code constants ADD..XOR; flag constants N=00, OC=01, B=10, Z=11; FSM state encoding.
- One sub-module, rr_arb2: combinational two-way round-robin grant from (valid0, valid1, last_gnt) to (gnt0, gnt1).

Test Plan:
- req0 add a=5 b=3 after reset -> req0_ready in accept cycle; 3 cycles later rsp_valid=1, result 8, flag 00, id 0.
- req1 sub a=3 b=5 -> result 62, flag 10, id 1. req0 and a=0x2A b=0x15 -> result 0, flag 11.
- Both valid from reset with add a=0x3F b=1 -> req0 served first (result 0, flag 01), then req1; sustained contention gives grant order 0,1,0,1.
- rsp_ready low 5 cycles in HOLD -> rsp_* stable, both readys 0, busy 1; rsp_ready high -> IDLE next cycle, new accept possible.
- rst pulsed in WAIT -> next cycle busy 0, rsp_valid 0, no response ever; first grant after release goes to req0.
- op 110, a=0x0F b=0x3C -> with OP_CHECK_EN: rsp_valid 1 cycle after accept, err 1, result 0. Without: result 0x33, err 0, 3-cycle latency.
